regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised two-read, one-write register file for the multicycle processor datapath. Generalised successor to the fixed 32x32 register file.
- Configurable width and depth, optional hardwired zero register, and a per-register pending scoreboard. The control FSM uses the scoreboard to detect read-after-write hazards on multicycle results.
- Sits between the decode/issue logic (reads, reservations) and the writeback stage (Load_En writes).

Parameters:
- SIZE, 32, data width of each register in bits.
- DEPTH, 32, number of registers; power of two, 2..64.
- SEL_W, 5, select width; must equal log2(DEPTH).
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never pending.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- Load_En  input  1  write enable for the writeback port.
- Dest_sel  input  SEL_W  write register index.
- D_data  input  SIZE  write data.
- A_sel  input  SEL_W  read port A index.
- B_sel  input  SEL_W  read port B index.
- Rsv_En  input  1  reserve request: mark Rsv_sel pending.
- Rsv_sel  input  SEL_W  register index to reserve.
- A_data  output  SIZE  read port A data, combinational.
- B_data  output  SIZE  read port B data, combinational.
- A_busy  output  1  pending bit of A_sel, combinational.
- B_busy  output  1  pending bit of B_sel, combinational.
- Hazard  output  1  A_busy | B_busy.
- Pend_cnt  output  SEL_W+1  number of currently pending registers.

Behaviour:
- Reset: clk edge with rst=1 clears all registers to 0, all pending bits to 0 and Pend_cnt to 0. Reset overrides any Load_En or Rsv_En in the same cycle. Outputs are 0 in the cycle after reset.
- Write: on a rising edge with Load_En=1, Reg[Dest_sel] <= D_data, and pending[Dest_sel] is cleared.
- Read: A_data = Reg[A_sel], B_data = Reg[B_sel], with zero-cycle latency. Without bypass, a read of the register being written in the same cycle returns the old value.
- Reserve: on a rising edge with Rsv_En=1, pending[Rsv_sel] <= 1. Reserving an already pending register is legal; the bit stays 1 and the count is unchanged.
- Simultaneous Load_En and Rsv_En on the same index: the write data is stored and pending ends at 1 (reserve wins, since it is a new producer). On different indices, both actions take effect.
- Load_En to a non-pending register: the data is written and pending stays 0 (unscheduled write is legal).
- Pend_cnt is registered and equals the popcount of the pending vector after each edge. It updates by +1, -1 or 0 per cycle; simultaneous set and clear of different bits yields net 0.
- Pend_cnt never exceeds DEPTH, or DEPTH-1 when ZERO_REG=1.
- ZERO_REG=1 and index 0:
  - writes are dropped;
  - reserve is ignored;
  - A_data/B_data read 0;
  - A_busy/B_busy read 0.
- Dest_sel and Rsv_sel out of range cannot occur, since the select width matches the depth.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when Load_En=1 and Dest_sel==A_sel, A_data = D_data in the same cycle and A_busy = 0, unless Rsv_En targets the same index. The same rule applies to port B.
- Defined, ZERO_REG=1: register 0 is never bypassed.
- Not defined: reads return stored contents only, and busy reflects the registered pending bits.
- Scoreboard update rules are identical in both builds.

Test Plan:
- Reset then read: rst=1 for 2 cycles, A_sel=3, B_sel=31 -> A_data=0, B_data=0, Pend_cnt=0, Hazard=0.
- Write/read: Load_En=1, Dest_sel=5, D_data=32'hDEADBEEF, then A_sel=5 next cycle -> A_data=32'hDEADBEEF. Then write to register 0 with ZERO_REG=1 -> reads 0.
- Scoreboard:
  - Rsv_En on reg 7 -> next cycle A_sel=7 gives A_busy=1, Hazard=1, Pend_cnt=1.
  - Load_En to 7 -> A_busy=0, Pend_cnt=0.
- Collision: same cycle Rsv_En on 9 and Load_En on 9 with 32'h1234 -> Reg[9]=32'h1234, pending[9]=1, Pend_cnt unchanged+1.
- Bypass (REGFILE_BYPASS_EN): Load_En=1, Dest_sel=A_sel=12, D_data=32'hA5A5A5A5 -> A_data=32'hA5A5A5A5 same cycle. Without the macro -> A_data = old value.
- Mid-operation reset: reserve regs 1..4 (Pend_cnt=4), assert rst together with Load_En=1 to 2 -> Pend_cnt=0, Reg[2]=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with a per-register pending scoreboard for hazard detection.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int SIZE     = 32,
    parameter int DEPTH    = 32,
    parameter int SEL_W    = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Load_En,
    input  logic [SEL_W-1:0] Dest_sel,
    input  logic [SIZE-1:0]  D_data,
    input  logic [SEL_W-1:0] A_sel,
    input  logic [SEL_W-1:0] B_sel,
    input  logic             Rsv_En,
    input  logic [SEL_W-1:0] Rsv_sel,
    output logic [SIZE-1:0]  A_data,
    output logic [SIZE-1:0]  B_data,
    output logic             A_busy,
    output logic             B_busy,
    output logic             Hazard,
    output logic [SEL_W:0]   Pend_cnt
);

    localparam logic [SEL_W:0] CNT_ONE = SEL_W'(1) + (SEL_W+1)'(0);

    logic [SIZE-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;
    logic [SEL_W:0]   pend_cnt_q;

    logic write_ok;
    logic rsv_ok;
    logic same_idx;
    logic cnt_inc;
    logic cnt_dec;

    // Index 0 is inert for both writes and reservations when hardwired to zero.
    assign write_ok = Load_En && !((ZERO_REG != 0) && (Dest_sel == '0));
    assign rsv_ok   = Rsv_En  && !((ZERO_REG != 0) && (Rsv_sel  == '0));
    assign same_idx = (Rsv_sel == Dest_sel);

    always_comb begin
        pending_nxt = pending;
        if (write_ok)
            pending_nxt[Dest_sel] = 1'b0;
        if (rsv_ok)
            pending_nxt[Rsv_sel] = 1'b1;
    end

    // A reservation on the written index keeps the bit set, so it cancels the clear.
    assign cnt_inc = rsv_ok && !pending[Rsv_sel];
    assign cnt_dec = write_ok && pending[Dest_sel] && !(rsv_ok && same_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pending    <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (write_ok)
                regs[Dest_sel] <= D_data;
            pending <= pending_nxt;
            if (cnt_inc && !cnt_dec)
                pend_cnt_q <= pend_cnt_q + CNT_ONE;
            else if (cnt_dec && !cnt_inc)
                pend_cnt_q <= pend_cnt_q - CNT_ONE;
        end
    end

    logic            a_zero;
    logic            b_zero;
    logic [SIZE-1:0] a_stored;
    logic [SIZE-1:0] b_stored;
    logic            a_pend;
    logic            b_pend;

    assign a_zero   = (ZERO_REG != 0) && (A_sel == '0);
    assign b_zero   = (ZERO_REG != 0) && (B_sel == '0);
    assign a_stored = a_zero ? '0 : regs[A_sel];
    assign b_stored = b_zero ? '0 : regs[B_sel];
    assign a_pend   = a_zero ? 1'b0 : pending[A_sel];
    assign b_pend   = b_zero ? 1'b0 : pending[B_sel];

`ifdef REGFILE_BYPASS_EN
    logic a_byp;
    logic b_byp;

    // write_ok already excludes a hardwired register 0 from forwarding.
    assign a_byp = write_ok && (Dest_sel == A_sel) && !(Rsv_En && same_idx);
    assign b_byp = write_ok && (Dest_sel == B_sel) && !(Rsv_En && same_idx);

    assign A_data = a_byp ? D_data : a_stored;
    assign B_data = b_byp ? D_data : b_stored;
    assign A_busy = a_byp ? 1'b0 : a_pend;
    assign B_busy = b_byp ? 1'b0 : b_pend;
`else
    assign A_data = a_stored;
    assign B_data = b_stored;
    assign A_busy = a_pend;
    assign B_busy = b_pend;
`endif

    assign Hazard   = A_busy | B_busy;
    assign Pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed plan steps, then random traffic against an array model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        Load_En;
    logic [4:0]  Dest_sel;
    logic [31:0] D_data;
    logic [4:0]  A_sel;
    logic [4:0]  B_sel;
    logic        Rsv_En;
    logic [4:0]  Rsv_sel;
    logic [31:0] A_data;
    logic [31:0] B_data;
    logic        A_busy;
    logic        B_busy;
    logic        Hazard;
    logic [5:0]  Pend_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_reg [32];
    bit          m_pend [32];
    bit          m_valid = 1'b0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .Load_En(Load_En), .Dest_sel(Dest_sel), .D_data(D_data),
        .A_sel(A_sel), .B_sel(B_sel), .Rsv_En(Rsv_En), .Rsv_sel(Rsv_sel),
        .A_data(A_data), .B_data(B_data), .A_busy(A_busy), .B_busy(B_busy),
        .Hazard(Hazard), .Pend_cnt(Pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] sel);
        logic [31:0] v;
        v = (sel == 0) ? 32'h0 : m_reg[sel];
`ifdef REGFILE_BYPASS_EN
        if (Load_En && Dest_sel == sel && sel != 0 && !(Rsv_En && Rsv_sel == Dest_sel))
            v = D_data;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] sel);
        logic b;
        b = (sel == 0) ? 1'b0 : m_pend[sel];
`ifdef REGFILE_BYPASS_EN
        if (Load_En && Dest_sel == sel && sel != 0 && !(Rsv_En && Rsv_sel == Dest_sel))
            b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [31:0] exp_count();
        int c = 0;
        for (int i = 0; i < 32; i++)
            c += int'(m_pend[i]);
        return 32'(c);
    endfunction

    // Drive one cycle, check combinational outputs against pre-edge model state, then advance the model.
    task automatic cycle(input logic rs, input logic le, input logic [4:0] ds, input logic [31:0] dd,
                         input logic [4:0] as, input logic [4:0] bs,
                         input logic re, input logic [4:0] rsel);
        logic ab;
        logic bb;
        rst = rs; Load_En = le; Dest_sel = ds; D_data = dd;
        A_sel = as; B_sel = bs; Rsv_En = re; Rsv_sel = rsel;
        #2;
        if (m_valid) begin
            ab = exp_busy(as);
            bb = exp_busy(bs);
            chk("a_data",   A_data,          exp_data(as));
            chk("b_data",   B_data,          exp_data(bs));
            chk("a_busy",   32'(A_busy),     32'(ab));
            chk("b_busy",   32'(B_busy),     32'(bb));
            chk("hazard",   32'(Hazard),     32'(ab | bb));
            chk("pend_cnt", 32'(Pend_cnt),   exp_count());
        end
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
            m_valid = 1'b1;
        end else begin
            if (le && ds != 0) begin
                m_reg[ds]  = dd;
                m_pend[ds] = 1'b0;
            end
            if (re && rsel != 0)
                m_pend[rsel] = 1'b1;
        end
        #1;
    endtask

    initial begin
        // reset then read
        cycle(1, 0, 0, 0, 3, 31, 0, 0);
        cycle(1, 0, 0, 0, 3, 31, 0, 0);
        cycle(0, 0, 0, 0, 3, 31, 0, 0);
        chk("reset_cnt_direct", 32'(Pend_cnt), 32'h0);

        // write/read, then write to register 0
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 5, 0, 0, 0);
        chk("deadbeef_direct", A_data, 32'hDEADBEEF);
        cycle(0, 1, 0, 32'hFFFF0000, 0, 5, 0, 0);
        cycle(0, 0, 0, 0, 0, 5, 0, 0);
        chk("zero_reg_direct", A_data, 32'h0);

        // scoreboard reserve / release
        cycle(0, 0, 0, 0, 0, 0, 1, 7);
        cycle(0, 0, 0, 0, 7, 0, 0, 0);
        chk("rsv7_busy_direct", 32'(A_busy), 32'h1);
        cycle(0, 1, 7, 32'h77, 7, 0, 0, 0);
        cycle(0, 0, 0, 0, 7, 0, 0, 0);
        chk("rel7_cnt_direct", 32'(Pend_cnt), 32'h0);

        // reserve reg 0 is ignored
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // collision on 9, then re-reserve pending 9 and write 9 while reserving
        cycle(0, 1, 9, 32'h1234, 9, 0, 1, 9);
        cycle(0, 0, 0, 0, 9, 9, 0, 0);
        chk("coll9_cnt_direct", 32'(Pend_cnt), 32'h1);
        cycle(0, 1, 9, 32'h5678, 9, 9, 1, 9);
        cycle(0, 0, 0, 0, 9, 0, 1, 9);
        cycle(0, 1, 9, 32'h9ABC, 9, 0, 1, 10);
        cycle(0, 0, 0, 0, 9, 10, 0, 0);

        // same-cycle read of the written register
        cycle(0, 1, 12, 32'h11111111, 0, 0, 0, 0);
        cycle(0, 1, 12, 32'hA5A5A5A5, 12, 12, 0, 0);
        cycle(0, 0, 0, 0, 12, 0, 0, 0);

        // mid-operation reset
        for (int r = 1; r <= 4; r++)
            cycle(0, 0, 0, 0, 0, 0, 1, 5'(r));
        cycle(0, 0, 0, 0, 2, 3, 0, 0);
        cycle(1, 1, 2, 32'hCAFEF00D, 0, 0, 1, 6);
        cycle(0, 0, 0, 0, 2, 6, 0, 0);
        chk("midreset_reg2_direct", A_data, 32'h0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [4:0] ds;
            logic [4:0] rsel;
            logic [4:0] as;
            ds   = 5'($urandom_range(0, 31));
            rsel = ($urandom_range(0, 3) == 0) ? ds : 5'($urandom_range(0, 31));
            as   = ($urandom_range(0, 3) == 0) ? ds : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1), ds, $urandom,
                  as, 5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0), rsel);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
